hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined MIPS core, sitting beside the decode-stage control unit. It tracks every in-flight register write (destination and remaining cycles to result, Tnew) through a configurable number of post-decode stages, compares it against the decode-stage operand demand (Tuse), and drives the pipeline stall and per-operand forwarding selects. It also owns the mult/div busy counter, so HI/LO-dependent instructions stall while the multi-cycle unit is running.

---
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-side hazard detection and forwarding control.
// Tracks in-flight register writes through the post-decode stages and
// compares each against the operand demand of the instruction in decode.
// Raises stall when a result cannot arrive in time. Picks the forwarding
// source for each operand. Also owns the mult/div busy counter that holds
// HI/LO users in decode while the multi-cycle unit is running.
module hazard_ctrl #(
  parameter int STAGES  = 3,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int FW      = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_kind,
  input  logic          d_md_use,
  output logic          stall,
  output logic [FW-1:0] fwd_rs_sel,
  output logic [FW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  // Counter wide enough for the longer of the two latencies.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  // An all-ones Tuse marks an operand the instruction does not read.
  localparam logic [TW-1:0] TUSE_NONE = '1;

  // Tracker: index 0 holds the instruction in E, index STAGES-1 the oldest.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [AW-1:0]     dst_q  [STAGES];
  logic [AW-1:0]     dst_d  [STAGES];
  logic [TW-1:0]     tnew_q [STAGES];
  logic [TW-1:0]     tnew_d [STAGES];

  // Mult/div busy counter.
  logic [CW-1:0] md_cnt_q;
  logic [CW-1:0] md_cnt_d;

  // Both decode operands share one evaluation path: index 0 = rs, 1 = rt.
  logic [AW-1:0] src_addr  [2];
  logic [TW-1:0] src_tuse  [2];
  logic [1:0]    src_stall;
  logic [FW-1:0] src_sel   [2];

  logic data_stall;
  logic md_stall;

  assign src_addr[0] = d_rs;
  assign src_addr[1] = d_rt;
  assign src_tuse[0] = d_tuse_rs;
  assign src_tuse[1] = d_tuse_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic          hit;
      logic [TW-1:0] hit_tnew;
      logic [FW-1:0] hit_stage;
      logic          blk_stall;
      logic [FW-1:0] blk_sel;

      // Find the youngest matching in-flight write. The loop runs from
      // the oldest entry to the youngest, so the last hit wins. Older
      // matches are shadowed because the youngest writer is the value
      // the program wants.
      always_comb begin
        hit       = 1'b0;
        hit_tnew  = '0;
        hit_stage = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
          if (valid_q[k] && (dst_q[k] == src_addr[gi]) &&
              (src_addr[gi] != '0) && (src_tuse[gi] != TUSE_NONE)) begin
            hit       = 1'b1;
            hit_tnew  = tnew_q[k];
            hit_stage = FW'(k + 1);
          end
        end
      end

      // Stall when the youngest writer's result arrives later than the
      // operand is needed. Forward only when that result already exists.
      always_comb begin
        blk_stall = 1'b0;
        blk_sel   = '0;
        if (hit) begin
          blk_stall = (hit_tnew > src_tuse[gi]);
          if (hit_tnew == '0) begin
            blk_sel = hit_stage;
          end
        end
      end

      assign src_stall[gi] = blk_stall;
      assign src_sel[gi]   = blk_sel;
    end
  endgenerate

  assign fwd_rs_sel = src_sel[0];
  assign fwd_rt_sel = src_sel[1];

  // Combine the stall sources. Only state and current decode inputs feed
  // this logic, so stall never loops back on itself.
  always_comb begin
    data_stall = |src_stall;
    md_busy    = (md_cnt_q != '0);
    md_stall   = d_md_use & md_busy;
    stall      = d_valid & (data_stall | md_stall);
  end

  // Next tracker state. Decode enters E unless it is stalled, in which
  // case a bubble enters. Every older entry moves down one stage and its
  // Tnew counts toward zero.
  always_comb begin
    valid_d   = '0;
    dst_d[0]  = d_dst;
    tnew_d[0] = d_tnew;
    valid_d[0] = d_valid & ~stall & (d_dst != '0);
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      dst_d[k]   = dst_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : (tnew_q[k-1] - TW'(1));
    end
  end

  // Next counter value. A start loads its latency; otherwise the counter
  // runs down to zero. A start that arrives while the unit is busy is
  // stalled, so it cannot reload the counter.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (d_valid && d_md_start && !stall) begin
      md_cnt_d = d_md_kind ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  // Tracker and counter registers. Reset drops every in-flight entry and
  // stops any running mult/div.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      md_cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dst_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      md_cnt_q <= md_cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        dst_q[k]  <= dst_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs are driven 1 time unit after
// each rising edge. Outputs are checked 1 time unit after that.
module tb_hazard_ctrl;

  localparam int STAGES  = 3;
  localparam int AW      = 5;
  localparam int TW      = 2;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int FW      = 2;

  logic          clk;
  logic          rst_n;
  logic          d_valid;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [AW-1:0] d_dst;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_kind;
  logic          d_md_use;
  logic          stall;
  logic [FW-1:0] fwd_rs_sel;
  logic [FW-1:0] fwd_rt_sel;
  logic          md_busy;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .STAGES(STAGES), .AW(AW), .TW(TW),
    .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FW(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start),
    .d_md_kind(d_md_kind), .d_md_use(d_md_use), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [TW-1:0] trs, input logic [TW-1:0] trt,
                       input logic [AW-1:0] dst, input logic [TW-1:0] tnew,
                       input logic ms, input logic mk, input logic mu);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_dst = dst; d_tnew = tnew; d_md_start = ms; d_md_kind = mk; d_md_use = mu;
  endtask

  task automatic set_nop();
    set_d(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_rand();
    set_d(1'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
          5'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic drain(input int n);
    set_nop();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // ---- reset with random decode inputs ----
    rst_n = 1'b0;
    set_rand();
    tick();
    set_rand();
    tick();
    rst_n = 1'b1;
    set_rand();
    d_valid = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_fwd_rs", 32'(fwd_rs_sel), 0);
    chk("rst_fwd_rt", 32'(fwd_rt_sel), 0);
    tick();
    drain(12);
    $display("step reset: stall=%0d md_busy=%0d", stall, md_busy);

    // ---- lw $1 (tnew 2) then add reading $1 (tuse 1) ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lw_issue_stall", 32'(stall), 0);
    tick();
    set_d(1'b1, 5'd1, 5'd0, 2'd1, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lw_add_stall", 32'(stall), 1);
    chk("lw_add_fwd_rs_stalled", 32'(fwd_rs_sel), 0);
    tick();
    #1;
    chk("lw_add_release", 32'(stall), 0);
    chk("lw_add_fwd_rs_m", 32'(fwd_rs_sel), 0);
    tick();
    set_d(1'b1, 5'd1, 5'd4, 2'd1, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lw_w_stall", 32'(stall), 0);
    chk("lw_w_fwd_rs", 32'(fwd_rs_sel), 3);
    chk("add_e_fwd_rt", 32'(fwd_rt_sel), 0);
    $display("step lw/add: stall=%0d fwd_rs=%0d fwd_rt=%0d", stall, fwd_rs_sel, fwd_rt_sel);
    tick();
    drain(3);

    // ---- ori $2 (tnew 1) then beq on $2 (tuse 0) ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd5, 5'd2, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("beq_stall", 32'(stall), 1);
    chk("beq_fwd_rt_stalled", 32'(fwd_rt_sel), 0);
    tick();
    #1;
    chk("beq_release", 32'(stall), 0);
    chk("beq_fwd_rt_m", 32'(fwd_rt_sel), 2);
    chk("beq_fwd_rs", 32'(fwd_rs_sel), 0);
    $display("step ori/beq: stall=%0d fwd_rt=%0d", stall, fwd_rt_sel);
    tick();
    drain(3);

    // ---- ori $2 then reader with tuse 1: no stall ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd2, 2'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ori_tuse1_stall", 32'(stall), 0);
    chk("ori_tuse1_fwd_rt", 32'(fwd_rt_sel), 0);
    $display("step ori/tuse1: stall=%0d fwd_rt=%0d", stall, fwd_rt_sel);
    tick();
    drain(3);

    // ---- two writers of $3: the youngest shadows the older ready one ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd3, 5'd0, 2'd2, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("shadow_stall", 32'(stall), 0);
    chk("shadow_fwd_rs", 32'(fwd_rs_sel), 0);
    set_d(1'b1, 5'd0, 5'd3, 2'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("shadow_rt_stall", 32'(stall), 1);
    chk("shadow_fwd_rt", 32'(fwd_rt_sel), 0);
    d_valid = 1'b0;
    #1;
    chk("invalid_no_stall", 32'(stall), 0);
    $display("step shadow: stall=%0d fwd_rs=%0d fwd_rt=%0d", stall, fwd_rs_sel, fwd_rt_sel);
    tick();
    drain(3);

    // ---- entry leaves the tracker after the last stage ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drain(2);
    set_d(1'b1, 5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("w_stage_stall", 32'(stall), 1);
    tick();
    #1;
    chk("falloff_stall", 32'(stall), 0);
    chk("falloff_fwd_rs", 32'(fwd_rs_sel), 0);
    $display("step falloff: stall=%0d fwd_rs=%0d", stall, fwd_rs_sel);
    tick();
    drain(3);

    // ---- div start, then a mult that must wait, then mflo ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("div_start_stall", 32'(stall), 0);
    chk("div_start_busy", 32'(md_busy), 0);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= DIV_LAT; i++) begin
      #1;
      chk($sformatf("div_busy_%0d", i), 32'(md_busy), 1);
      chk($sformatf("div_wait_stall_%0d", i), 32'(stall), 1);
      tick();
    end
    #1;
    chk("div_done_busy", 32'(md_busy), 0);
    chk("div_done_stall", 32'(stall), 0);
    $display("step div: busy=%0d stall=%0d", md_busy, stall);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= MUL_LAT; i++) begin
      #1;
      chk($sformatf("mul_busy_%0d", i), 32'(md_busy), 1);
      chk($sformatf("mflo_stall_%0d", i), 32'(stall), 1);
      tick();
    end
    #1;
    chk("mul_done_busy", 32'(md_busy), 0);
    chk("mflo_release", 32'(stall), 0);
    $display("step mult: busy=%0d stall=%0d", md_busy, stall);
    tick();
    drain(2);

    // ---- reset during a multiply drops counter and tracker ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd3, 1'b1, 1'b0, 1'b1);
    tick();
    set_nop();
    #1;
    chk("mid_mul_busy", 32'(md_busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_d(1'b1, 5'd6, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("post_rst_busy", 32'(md_busy), 0);
    chk("post_rst_stall", 32'(stall), 0);
    $display("step mid-reset: busy=%0d stall=%0d", md_busy, stall);
    tick();
    drain(3);

    // ---- writes to $0 never stall or forward ----
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("r0_stall", 32'(stall), 0);
    chk("r0_fwd_rs", 32'(fwd_rs_sel), 0);
    chk("r0_fwd_rt", 32'(fwd_rt_sel), 0);
    $display("step r0: stall=%0d fwd_rs=%0d fwd_rt=%0d", stall, fwd_rs_sel, fwd_rt_sel);
    tick();
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
